// File: rtl/seq_lock.sv
// seq_lock: sequence-entry lock for the board front panel.
// Synchronises and debounces a W-bit switch bank, turns each debounced
// press into a one-cycle token, and matches the tokens against the programmed
// sequence SEQ. After MAX_FAIL wrong tokens the lock goes into a timed lockout.
// Ports:
//   clk        system clock, rising edge
//   key        asynchronous active-low reset
//   sw         raw switch bank (asynchronous to clk)
//   led        01 entry/no progress, 10 entry/progress, 11 open, 00 lockout
//   progress   correct tokens accepted so far (N when open, 0 in lockout)
//   unlock     high while open
//   locked_out high while in lockout
module seq_lock #(
  parameter int             W              = 4,
  parameter int             N              = 4,
  parameter logic [N*W-1:0] SEQ            = {4'b1000, 4'b0100, 4'b0010, 4'b0001},
  parameter int             STABLE_CYCLES  = 1_000_000,
  parameter int             MAX_FAIL       = 3,
  parameter int             LOCKOUT_CYCLES = 50_000_000
) (
  input  logic                   clk,
  input  logic                   key,
  input  logic [W-1:0]           sw,
  output logic [1:0]             led,
  output logic [$clog2(N+1)-1:0] progress,
  output logic                   unlock,
  output logic                   locked_out
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int IW = $clog2(N);
  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam int PW = $clog2(N + 1);

  localparam logic [CW-1:0] CNT_MAX   = CW'(STABLE_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {ST_ENTRY, ST_OPEN, ST_LOCKOUT} state_e;

  // ---------------- input path ----------------
  logic [W-1:0]  sw_meta_q, sw_sync_q, held_q;
  logic [CW-1:0] cnt_q;
  logic          armed_q;
  logic          stable, tok;

  // The counter saturates, so "stable" stays high while the value is held;
  // armed_q is what turns that level into a single token per press.
  assign stable = (cnt_q == CNT_MAX);
  assign tok    = stable && (held_q != '0) && armed_q;

  always_ff @(posedge clk or negedge key) begin
    if (!key) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      held_q    <= '0;
      cnt_q     <= '0;
      armed_q   <= 1'b0;
    end else begin
      sw_meta_q <= sw;
      sw_sync_q <= sw_meta_q;
      if (sw_sync_q != held_q) begin
        held_q <= sw_sync_q;
        cnt_q  <= '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
      // A press consumes the arm; only a stable all-released bank re-arms.
      if (tok)                          armed_q <= 1'b0;
      else if (stable && held_q == '0)  armed_q <= 1'b1;
    end
  end

  // ---------------- sequence FSM ----------------
  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [FW-1:0] fail_q, fail_d;
  logic [LW-1:0] lcnt_q, lcnt_d;

  always_ff @(posedge clk or negedge key) begin
    if (!key) begin
      state_q <= ST_ENTRY;
      idx_q   <= '0;
      fail_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      lcnt_q  <= lcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    lcnt_d  = lcnt_q;
    case (state_q)
      ST_ENTRY: begin
        if (tok) begin
          if (held_q == SEQ[int'(idx_q)*W +: W]) begin
            if (idx_q == IDX_LAST) begin
              state_d = ST_OPEN;
              idx_d   = '0;
              fail_d  = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            // Wrong token restarts entry; it is not retried as the first entry.
            idx_d = '0;
            if (fail_q == FAIL_LAST) begin
              state_d = ST_LOCKOUT;
              fail_d  = '0;
              lcnt_d  = LOCK_LOAD;
            end else begin
              fail_d = fail_q + 1'b1;
            end
          end
        end
      end
      ST_OPEN: begin
        if (tok) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
        end
      end
      ST_LOCKOUT: begin
        // Counts LOCKOUT_CYCLES-1 down to 0, so the state lasts exactly
        // LOCKOUT_CYCLES cycles; tokens are ignored throughout.
        if (lcnt_q == '0) begin
          state_d = ST_ENTRY;
          idx_d   = '0;
        end else begin
          lcnt_d = lcnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_ENTRY;
        idx_d   = '0;
      end
    endcase
  end

  // ---------------- output decode ----------------
  always_comb begin
    led        = 2'b01;
    progress   = '0;
    unlock     = 1'b0;
    locked_out = 1'b0;
    case (state_q)
      ST_ENTRY: begin
        led      = (idx_q == '0) ? 2'b01 : 2'b10;
        progress = PW'(idx_q);
      end
      ST_OPEN: begin
        led      = 2'b11;
        progress = PW'(N);
        unlock   = 1'b1;
      end
      ST_LOCKOUT: begin
        led        = 2'b00;
        locked_out = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
